// File: rtl/blur_pkg.sv
// Shared pixel/window types for the blur pipeline (window builder and gaussian_blurrer).
package blur_pkg;

    localparam int unsigned PX_WIDTH    = 8;
    localparam int unsigned WIN         = 5;
    localparam int unsigned FILTER_SIZE = WIN * WIN;
    localparam int unsigned COORD_W     = 10;

    typedef logic [PX_WIDTH-1:0] px_t;
    typedef logic [COORD_W-1:0]  coord_t;
    typedef px_t window_t [0:FILTER_SIZE-1];

endpackage

// File: rtl/line_delay.sv
// One line of pixel storage: single write port, combinational read at the same address.
module line_delay
    import blur_pkg::*;
#(
    parameter int unsigned LINE_WIDTH = 640,
    parameter int unsigned AW         = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       addr,
    input  logic [PX_WIDTH-1:0] wdata,
    output logic [PX_WIDTH-1:0] rdata
);

    px_t mem_q [0:LINE_WIDTH-1];

    // Contents are never cleared; the row counter keeps stale data out of any window.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/blur_window_builder.sv
// Streaming 5x5 window generator: four chained line delays feed a 5x5 shift register,
// emitting one window per accepted pixel whose full neighbourhood is inside the frame.
module blur_window_builder
    import blur_pkg::*;
#(
    parameter int unsigned LINE_WIDTH = 640
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PX_WIDTH-1:0] px_in,
    input  logic                px_valid,
    input  logic                px_sof,
    output logic                px_ready,
    output logic [PX_WIDTH-1:0] win [0:FILTER_SIZE-1],
    output logic                win_valid,
    input  logic                win_ready,
    output logic [COORD_W-1:0]  win_row,
    output logic [COORD_W-1:0]  win_col
);

    localparam int unsigned AW      = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam int unsigned NUM_LB  = WIN - 1;
    localparam coord_t      LastCol = coord_t'(LINE_WIDTH - 1);
    localparam coord_t      MaxRow  = '1;
    localparam coord_t      Edge    = coord_t'(WIN - 1);
    localparam coord_t      Half    = coord_t'(WIN / 2);

    coord_t  row_q, row_d, col_q, col_d;
    coord_t  win_row_q, win_row_d, win_col_q, win_col_d;
    logic    win_valid_q, win_valid_d;
    window_t win_q, win_d;

    coord_t  cur_row, cur_col;
    logic    accept, emit;
    logic [AW-1:0] lb_addr;
    px_t     lb_rd [0:NUM_LB-1];
    px_t     lb_wr [0:NUM_LB-1];
    px_t     new_col [0:WIN-1];

    assign px_ready = !win_valid_q | win_ready;
    assign accept   = px_valid & px_ready;

    // A start-of-frame pixel is placed at (0,0) regardless of the running count.
    assign cur_row = px_sof ? '0 : row_q;
    assign cur_col = px_sof ? '0 : col_q;
    assign lb_addr = cur_col[AW-1:0];
    assign emit    = accept && (cur_row >= Edge) && (cur_col >= Edge);

    // LB0 is oldest (row-4), LB3 newest (row-1); each line moves one buffer up on accept.
    always_comb begin
        for (int unsigned i = 0; i < NUM_LB - 1; i++) begin
            lb_wr[i] = lb_rd[i+1];
        end
        lb_wr[NUM_LB-1] = px_in;
        for (int unsigned r = 0; r < NUM_LB; r++) begin
            new_col[r] = lb_rd[r];
        end
        new_col[WIN-1] = px_in;
    end

    for (genvar g = 0; g < NUM_LB; g++) begin : g_lb
        line_delay #(
            .LINE_WIDTH (LINE_WIDTH),
            .AW         (AW)
        ) u_line_delay (
            .clk   (clk),
            .we    (accept & ~reset),
            .addr  (lb_addr),
            .wdata (lb_wr[g]),
            .rdata (lb_rd[g])
        );
    end

    always_comb begin
        row_d       = row_q;
        col_d       = col_q;
        win_d       = win_q;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        win_valid_d = win_valid_q;

        if (accept) begin
            if (cur_col == LastCol) begin
                col_d = '0;
                row_d = (cur_row == MaxRow) ? cur_row : cur_row + coord_t'(1);
            end else begin
                col_d = cur_col + coord_t'(1);
                row_d = cur_row;
            end
            for (int unsigned r = 0; r < WIN; r++) begin
                for (int unsigned c = 0; c < WIN - 1; c++) begin
                    win_d[r*WIN+c] = win_q[r*WIN+c+1];
                end
                win_d[r*WIN+WIN-1] = new_col[r];
            end
        end

        // A freshly emitted window overrides the consume of the previous one.
        if (emit) begin
            win_valid_d = 1'b1;
            win_row_d   = cur_row - Half;
            win_col_d   = cur_col - Half;
        end else if (win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_q       <= '0;
            col_q       <= '0;
            win_q       <= '{default: '0};
            win_row_q   <= '0;
            win_col_q   <= '0;
            win_valid_q <= 1'b0;
        end else begin
            row_q       <= row_d;
            col_q       <= col_d;
            win_q       <= win_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
            win_valid_q <= win_valid_d;
        end
    end

    assign win       = win_q;
    assign win_valid = win_valid_q;
    assign win_row   = win_row_q;
    assign win_col   = win_col_q;

endmodule
